// File: rtl/keypad_debounce_if.sv
// Keypad bundle: raw push-buttons toward the debouncer, qualified key outputs back.
// slave is the debouncer side; master is the consumer/driver side.
interface keypad_debounce_if;
  logic [19:0] pb;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [19:0] key_bits;
  logic        key_held;
  logic        multi_key;

  modport master (
    output pb,
    input  key_valid, key_code, key_bits, key_held, multi_key
  );

  modport slave (
    input  pb,
    output key_valid, key_code, key_bits, key_held, multi_key
  );
endinterface

// File: rtl/keypad_debounce.sv
// Keypad debouncer: synchronizes pb into hz100, qualifies press/release, strobes key_valid.
// Optional digit auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_RATE     = 10
) (
  input logic              hz100,
  input logic              reset,
  keypad_debounce_if.slave kp
);

  typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [19:0] s1_q, s2_q;
  logic [19:0] cand_q, cand_d;
  logic [19:0] bits_q, bits_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic        s2_zero;

  assign s2_zero = (s2_q == '0);

  // Highest set index wins.
  function automatic logic [4:0] enc(input logic [19:0] v);
    enc = '0;
    for (int i = 0; i < 20; i++) begin
      if (v[i]) enc = 5'(i);
    end
  endfunction

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rpt_q, rpt_d;
  logic        first_q, first_d;
  logic        rpt_fire;

  // first_q selects the initial delay; later repeats use the rate.
  assign rpt_fire = (state_q == StHeld) && !s2_zero && (code_q <= 5'd9) &&
                    (rpt_q == (first_q ? 16'(REPEAT_DELAY - 1) : 16'(REPEAT_RATE - 1)));
`else
  logic unused_rpt_params;
  assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  always_ff @(posedge hz100) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:        if (!s2_zero) state_d = StPressWait;
      StPressWait: begin
        if (s2_zero)                                 state_d = StIdle;
        else if (s2_q == cand_q && cnt_q == CntLast) state_d = StHeld;
      end
      StHeld:        if (s2_zero) state_d = StReleaseWait;
      StReleaseWait: begin
        if (!s2_zero)             state_d = StHeld;
        else if (cnt_q == CntLast) state_d = StIdle;
      end
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    code_d  = code_q;
    held_d  = held_q;
    valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d   = rpt_q;
    first_d = first_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!s2_zero) begin
          cand_d = s2_q;
          cnt_d  = 8'd1;
        end
      end
      StPressWait: begin
        if (!s2_zero) begin
          if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = 8'd1;
          end else if (cnt_q == CntLast) begin
            bits_d  = cand_q;
            code_d  = enc(cand_q);
            held_d  = 1'b1;
            valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rpt_d   = '0;
            first_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StHeld: begin
        if (s2_zero) begin
          cnt_d = 8'd1;
`ifdef KEYPAD_REPEAT_EN
          rpt_d   = '0;
          first_d = 1'b1;
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rpt_fire) begin
          valid_d = 1'b1;
          rpt_d   = '0;
          first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + 16'd1;
        end
`endif
      end
      StReleaseWait: begin
        if (!s2_zero) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          held_d = 1'b0;
          bits_d = '0;
          code_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      code_q  <= '0;
      held_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= '0;
      first_q <= 1'b1;
`endif
    end else begin
      s1_q    <= kp.pb;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      code_q  <= code_d;
      held_q  <= held_d;
      valid_q <= valid_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= rpt_d;
      first_q <= first_d;
`endif
    end
  end

  // Clearing the lowest set bit leaves a nonzero value only when two or more bits are set.
  always_comb begin
    kp.key_valid = valid_q;
    kp.key_code  = code_q;
    kp.key_bits  = bits_q;
    kp.key_held  = held_q;
    kp.multi_key = held_q && ((bits_q & (bits_q - 20'd1)) != '0);
  end

endmodule
